// File: rtl/spram_arb_pkg.sv
// spram_arb_pkg: shared state encoding, default widths and pointer-width helper
// for the single-port RAM round-robin arbiter.
package spram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_N_REQ          = 4;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    function automatic int ptr_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or after ptr,
// found by masking a doubled request vector and isolating its lowest set bit.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    always_comb begin
        masked = {req, req} & ({(2*N){1'b1}} << ptr);
        first  = masked & (-masked);
        grant  = first[N-1:0] | first[2*N-1:N];
        idx    = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) idx = PW'(i);
    end

endmodule

// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: round-robin arbiter sharing one single-port RAM among N_REQ requesters.
// Define SPRAM_ARB_TIMEOUT_EN to add an ISSUE-state watchdog of TIMEOUT_CYCLES.
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        err,
    output logic                        busy,
    output logic                        ram_en,
    output logic                        ram_valid,
    output logic                        ram_wr_rd,
    output logic [ADDR_WIDTH-1:0]       ram_addr,
    output logic [DATA_WIDTH-1:0]       ram_din,
    input  logic [DATA_WIDTH-1:0]       ram_dout,
    input  logic                        ram_ready,
    input  logic                        ram_error
);

    localparam int PW = ptr_width(N_REQ);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [N_REQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            expired;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx)
    );

`ifdef SPRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    assign expired = (wd_cnt == CW'(TIMEOUT_CYCLES));
    // Held at zero outside ISSUE so every transaction starts counting from 0.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) wd_cnt <= '0;
        else if (state != ISSUE) wd_cnt <= '0;
        else wd_cnt <= wd_cnt + 1'b1;
`else
    logic unused_timeout;
    assign expired = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_valid <= 1'b0;
            ram_wr_rd <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    owner     <= pick_idx;
                    ram_en    <= 1'b1;
                    ram_valid <= 1'b1;
                    ram_wr_rd <= |(req_wr & pick_gnt);
                    ram_addr  <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_din   <= req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                // ready wins over a simultaneous watchdog expiry
                ISSUE: if (ram_ready || expired) begin
                    if (ram_ready && !ram_wr_rd) rdata <= ram_dout;
                    err       <= ram_ready ? ram_error : 1'b1;
                    done      <= N_REQ'(1) << owner;
                    ram_en    <= 1'b0;
                    ram_valid <= 1'b0;
                    ram_wr_rd <= 1'b0;
                    ram_addr  <= '0;
                    ram_din   <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb_spram_rr_arbiter: scoreboard bench for spram_rr_arbiter with a behavioural RAM
// that supports programmable wait states, a never-ready mode and range errors at 5'h1F.
module tb_spram_rr_arbiter;

    localparam int N = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          busy;
    logic          ram_en, ram_valid, ram_wr_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_ready;
    logic          ram_error;

    spram_rr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .ram_en    (ram_en),
        .ram_valid (ram_valid),
        .ram_wr_rd (ram_wr_rd),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_ready (ram_ready),
        .ram_error (ram_error)
    );

    always #5 clk = ~clk;

    // RAM model: default contents 32'h1000_0000 | addr, ready after wait_cycles in-transaction cycles
    logic [DW-1:0] mem [32];
    logic          mem_init = 1'b0;
    int            wait_cycles = 0;
    logic          never_ready = 1'b0;
    int            wcnt = 0;

    assign ram_dout  = mem[ram_addr];
    assign ram_error = ram_en && (ram_addr == 5'h1F);
    assign ram_ready = ram_en && ram_valid && !never_ready && (wcnt == wait_cycles);

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 32; a++) mem[a] <= 32'h1000_0000 | a;
            mem_init <= 1'b1;
        end else if (ram_ready && ram_wr_rd && !ram_error) begin
            mem[ram_addr] <= ram_din;
        end
        wcnt <= (ram_en && !ram_ready) ? wcnt + 1 : 0;
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (done != '0) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_owner", 64'(done), 64'(4'b0001 << e.idx));
                chk("done_err", 64'(err), 64'(e.err));
                chk("done_rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    task automatic set_op(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int i, input logic [DW-1:0] rd, input logic e);
        exp_t x;
        x.idx = i;
        x.rdata = rd;
        x.err = e;
        q.push_back(x);
    endtask

    // Raise requests in an idle cycle; drop each non-held req on its done; bounded wait
    task automatic run(input logic [N-1:0] raise, input logic [N-1:0] hold, input int n,
                       output int first_cyc, output int en_cyc);
        int seen = 0;
        int cyc = 0;
        first_cyc = -1;
        en_cyc = 0;
        req = req | raise;
        while (seen < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ram_en && ram_valid) en_cyc++;
            for (int i = 0; i < N; i++)
                if (done[i]) begin
                    seen++;
                    if (first_cyc < 0) first_cyc = cyc;
                    if (!hold[i]) req[i] = 1'b0;
                end
        end
        chk("dones_seen", 64'(seen), 64'(n));
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        int fc, ec, cyc;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        chk("rst_ram_valid", 64'(ram_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // single write then read by requester 1
        set_op(1, 1'b1, 5'h03, 32'h3A3A_3A3A);
        push(1, 32'h0, 1'b0);
        run(4'b0010, 4'b0000, 1, fc, ec);
        set_op(1, 1'b0, 5'h03, 32'h0);
        push(1, 32'h3A3A_3A3A, 1'b0);
        run(4'b0010, 4'b0000, 1, fc, ec);
        chk("zero_wait_latency", 64'(fc), 64'd2);
        chk("zero_wait_en_cycles", 64'(ec), 64'd1);

        // four wait states
        wait_cycles = 4;
        set_op(3, 1'b0, 5'h0C, 32'h0);
        push(3, 32'h1000_000C, 1'b0);
        run(4'b1000, 4'b0000, 1, fc, ec);
        chk("wait4_latency", 64'(fc), 64'd6);
        chk("wait4_en_cycles", 64'(ec), 64'd5);
        wait_cycles = 0;

        // RAM range error forwarded; rdata keeps the previous read
        set_op(0, 1'b1, 5'h1F, 32'hDEAD_BEEF);
        push(0, 32'h1000_000C, 1'b1);
        run(4'b0001, 4'b0000, 1, fc, ec);

        // asynchronous reset in the middle of a pending write
        wait_cycles = 10;
        set_op(2, 1'b1, 5'h08, 32'h5555_5555);
        req[2] = 1'b1;
        cyc = 0;
        while (!ram_en && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("midissue_en", 64'(ram_en), 64'd1);
        chk("midissue_busy", 64'(busy), 64'd1);
        chk("midissue_addr", 64'(ram_addr), 64'h08);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_ram_en", 64'(ram_en), 64'd0);
        chk("arst_ram_valid", 64'(ram_valid), 64'd0);
        chk("arst_ram_wr_rd", 64'(ram_wr_rd), 64'd0);
        chk("arst_ram_addr", 64'(ram_addr), 64'd0);
        chk("arst_ram_din", 64'(ram_din), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        req = '0;
        @(negedge clk);
        rstn = 1'b1;
        wait_cycles = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_reset", 64'(done), 64'd0);
        end
        chk("aborted_write_absent", 64'(mem[8]), 64'h1000_0008);

        // contention from ptr=0, twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) set_op(i, 1'b0, 5'(10 + i), 32'h0);
            push(0, 32'h1000_000A, 1'b0);
            push(1, 32'h1000_000B, 1'b0);
            push(2, 32'h1000_000C, 1'b0);
            push(3, 32'h1000_000D, 1'b0);
            run(4'b1111, 4'b0000, 4, fc, ec);
        end

        // requesters 0 and 2 held high: alternate with ptr wrapping 3 -> 0
        set_op(0, 1'b0, 5'h10, 32'h0);
        set_op(2, 1'b0, 5'h12, 32'h0);
        push(0, 32'h1000_0010, 1'b0);
        push(2, 32'h1000_0012, 1'b0);
        push(0, 32'h1000_0010, 1'b0);
        push(2, 32'h1000_0012, 1'b0);
        run(4'b0101, 4'b0101, 4, fc, ec);

`ifdef SPRAM_ARB_TIMEOUT_EN
        never_ready = 1'b1;
        set_op(1, 1'b0, 5'h05, 32'h0);
        push(1, 32'h1000_0012, 1'b1);
        run(4'b0010, 4'b0000, 1, fc, ec);
        chk("timeout_latency", 64'(fc), 64'd17);
        never_ready = 1'b0;
        set_op(2, 1'b0, 5'h06, 32'h0);
        push(2, 32'h1000_0006, 1'b0);
        run(4'b0100, 4'b0000, 1, fc, ec);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
